// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver.
//
// Collects the bytes from uart_byte_rx into a frame buffer. A frame ends
// when the bus has been silent for 3.5 character times. The CRC-16/MODBUS
// value and the slave address are checked while the frame arrives. After a
// good frame, the request decoder reads the frame through a registered
// read port.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   rx_data        received byte, valid when rx_done is high
//   rx_done        1-cycle strobe per received byte
//   rx_drop_frame  1.5T inter-byte gap violation from ct_15t_gen
//   dev_addr       own slave address (static)
//   rd_addr        buffer read address
//   rd_data        buffer byte, one cycle after rd_addr
//   frame_valid    1-cycle pulse: a frame of acceptable length ended
//   frame_err      1-cycle pulse: a frame was discarded
//   frame_len      byte count of the last good frame, CRC included
//   crc_ok         last good frame had a zero CRC residue
//   addr_match     last good frame was addressed to us or was a broadcast
//   rx_busy        a frame is being received
module modbus_rtu_frame_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int ADDR_W     = 8,
  parameter int T35_CYCLES = (CLK_FREQ / BAUD_RATE) * 385 / 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              rx_drop_frame,
  input  logic [7:0]        dev_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [ADDR_W:0]   frame_len,
  output logic              crc_ok,
  output logic              addr_match,
  output logic              rx_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SIL_W = $clog2(T35_CYCLES + 1);
  localparam logic [SIL_W-1:0] SIL_MAX   = SIL_W'(T35_CYCLES);
  localparam logic [ADDR_W:0]  COUNT_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  MIN_LEN   = (ADDR_W + 1)'(4);

  typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_t;

  state_t            state;
  logic [SIL_W-1:0]  sil_cnt;
  logic              t35;
  logic [15:0]       crc;
  logic [ADDR_W:0]   count;
  logic [7:0]        first_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        mem [DEPTH];

  // CRC-16/MODBUS with all eight bit steps of one byte done in a single cycle.
  function automatic logic [15:0] crc_update(input logic [15:0] crc_in, input logic [7:0] b);
    logic [15:0] c;
    c = crc_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign t35     = (sil_cnt == SIL_MAX);
  assign rx_busy = (state == RECV);

  // A byte is stored only when it opens a frame or extends one that still
  // has room. When a drop and a byte arrive together, the byte is discarded.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = count[ADDR_W-1:0];
    if (rx_done) begin
      if (state == IDLE) begin
        wr_en   = 1'b1;
        wr_addr = '0;
      end else if (state == RECV && !rx_drop_frame && count != COUNT_MAX) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= rx_data;
  end

  // A read and a write to the same address in one cycle return the old byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= mem[rd_addr];
  end

  // Frame state machine. The silence counter runs in every state, so the
  // end-of-frame timer also covers the post-reset sync and the drop state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      sil_cnt     <= '0;
      crc         <= 16'hFFFF;
      count       <= '0;
      first_byte  <= 8'h00;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_len   <= '0;
      crc_ok      <= 1'b0;
      addr_match  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (rx_done)   sil_cnt <= '0;
      else if (!t35) sil_cnt <= sil_cnt + 1'b1;

      case (state)
        SYNC: begin
          if (t35) state <= IDLE;
        end
        IDLE: begin
          if (rx_done) begin
            count      <= (ADDR_W + 1)'(1);
            crc        <= crc_update(16'hFFFF, rx_data);
            first_byte <= rx_data;
            state      <= RECV;
          end
        end
        RECV: begin
          if (rx_drop_frame) begin
            state <= DROP;
          end else if (rx_done) begin
            if (count == COUNT_MAX) begin
              state <= DROP;
            end else begin
              count <= count + 1'b1;
              crc   <= crc_update(crc, rx_data);
            end
          end else if (t35) begin
            if (count >= MIN_LEN) begin
              frame_valid <= 1'b1;
              frame_len   <= count;
              crc_ok      <= (crc == 16'h0000);
              addr_match  <= (first_byte == dev_addr) || (first_byte == 8'h00);
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        DROP: begin
          if (t35) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule
